// File: rtl/grostl_pkg.sv
// Shared constants and types for the Grostl-512-state message path.
package grostl_pkg;

  localparam int GROSTL_WORD_W   = 64;
  localparam int GROSTL_BLK_WORDS = 8;
  localparam int GROSTL_BLK_W    = 512;
  localparam logic [63:0] GROSTL_PAD_MARK = 64'h8000_0000_0000_0000;

  typedef enum logic [1:0] {LD_FILL, LD_PAD, LD_HOLD} loader_state_t;

  typedef logic [511:0] grostl_blk_t;

endpackage

// File: rtl/grostl_msg_loader.sv
// Assembles 64-bit message words into 512-bit Grostl blocks with word-granular
// padding (marker, zero fill, block-count field) and a valid/ready hold stage.
module grostl_msg_loader
  import grostl_pkg::*;
#(
  parameter int WORD_W    = GROSTL_WORD_W,
  parameter int BLK_WORDS = GROSTL_BLK_WORDS,
  parameter int LEN_W     = WORD_W
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [WORD_W-1:0]           in_data,
  input  logic                        in_valid,
  input  logic                        in_last,
  output logic                        in_ready,
  output logic [WORD_W*BLK_WORDS-1:0] blk_data,
  output logic                        valid_out,
  output logic                        blk_last,
  input  logic                        blk_ready
);

  localparam int BLK_W = WORD_W * BLK_WORDS;
  localparam int IDX_W = $clog2(BLK_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLK_WORDS - 1);

  loader_state_t     r_state, w_state_nxt;
  logic [IDX_W-1:0]  r_widx, w_widx_nxt;
  logic [BLK_W-1:0]  r_buf, w_buf_nxt;
  logic [LEN_W-1:0]  r_blk_cnt, w_blk_cnt_nxt;
  logic              r_pad_pend, w_pad_pend_nxt;
  logic              r_mark_done, w_mark_done_nxt;
  logic              r_final, w_final_nxt;
  logic              w_wr_en;
  logic [WORD_W-1:0] w_wr_word;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= LD_FILL;
      r_widx      <= '0;
      r_buf       <= '0;
      r_blk_cnt   <= '0;
      r_pad_pend  <= 1'b0;
      r_mark_done <= 1'b0;
      r_final     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_widx      <= w_widx_nxt;
      r_buf       <= w_buf_nxt;
      r_blk_cnt   <= w_blk_cnt_nxt;
      r_pad_pend  <= w_pad_pend_nxt;
      r_mark_done <= w_mark_done_nxt;
      r_final     <= w_final_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_widx_nxt      = r_widx;
    w_buf_nxt       = r_buf;
    w_blk_cnt_nxt   = r_blk_cnt;
    w_pad_pend_nxt  = r_pad_pend;
    w_mark_done_nxt = r_mark_done;
    w_final_nxt     = r_final;
    w_wr_en         = 1'b0;
    w_wr_word       = '0;

    case (r_state)
      LD_FILL: begin
        if (in_valid) begin
          w_wr_en    = 1'b1;
          w_wr_word  = in_data;
          w_widx_nxt = r_widx + 1'b1;
          if (in_last) w_pad_pend_nxt = 1'b1;
          if (r_widx == LAST_IDX) begin
            w_blk_cnt_nxt = r_blk_cnt + 1'b1;
            w_state_nxt   = LD_HOLD;
          end else if (in_last) begin
            w_state_nxt = LD_PAD;
          end
        end
      end
      LD_PAD: begin
        w_wr_en    = 1'b1;
        w_widx_nxt = r_widx + 1'b1;
        if (!r_mark_done) begin
          w_wr_word       = GROSTL_PAD_MARK;
          w_mark_done_nxt = 1'b1;
        end else if (r_widx == LAST_IDX) begin
          w_wr_word = WORD_W'(r_blk_cnt + 1'b1);
        end
        // A marker landing in the last slot forces one more all-padding block.
        if (r_widx == LAST_IDX) begin
          w_blk_cnt_nxt = r_blk_cnt + 1'b1;
          w_final_nxt   = r_mark_done;
          w_state_nxt   = LD_HOLD;
        end
      end
      LD_HOLD: begin
        if (blk_ready) begin
          if (r_final) begin
            w_blk_cnt_nxt   = '0;
            w_pad_pend_nxt  = 1'b0;
            w_mark_done_nxt = 1'b0;
            w_final_nxt     = 1'b0;
            w_state_nxt     = LD_FILL;
          end else if (r_pad_pend) begin
            w_state_nxt = LD_PAD;
          end else begin
            w_state_nxt = LD_FILL;
          end
        end
      end
      default: w_state_nxt = LD_FILL;
    endcase

    if (w_wr_en) w_buf_nxt[BLK_W-1-WORD_W*int'(r_widx) -: WORD_W] = w_wr_word;
  end

  assign in_ready  = (r_state == LD_FILL);
  assign valid_out = (r_state == LD_HOLD);
  assign blk_last  = r_final & (r_state == LD_HOLD);
  assign blk_data  = r_buf;

endmodule
